// File: rtl/pipelined_mac_multiplier.sv
// Iterative chunked multiplier with signed/unsigned operands and an internal multiply-accumulate register.
// Build option: define PIPELINED_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module pipelined_mac_multiplier #(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned CHUNK     = 6,
  parameter int unsigned ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic [1:0]           mode,
  input  logic                 input_rdy,
  output logic                 busy,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   p,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);

  localparam int unsigned PW    = 2*WIDTH;
  localparam int unsigned N     = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]     LAST     = CNT_W'(N - 1);
  localparam logic [ACC_WIDTH-1:0] EXT_MASK = {ACC_WIDTH{1'b1}} << PW;
`ifdef PIPELINED_MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    MODE_MUL  = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_SUB  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_e;

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept_c, iter_c, finish_c;

  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sgn_q;
  mode_e            mode_q;
  logic [PW-1:0]    psum;

  logic [PW-1:0]    a_ext_c;
  logic [CHUNK-1:0] slice_c;
  logic             top_neg_c;
  logic [PW-1:0]    term_c;
  logic [WIDTH-1:0] b_next_c;

  logic [ACC_WIDTH-1:0] p_ext_c, addend_c, sum_c, mac_c;
  logic                 is_sub_c, ovf_c;

  // Sequencer: idle -> N slice iterations -> one completion cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    iter_c     = 1'b0;
    finish_c   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (input_rdy) begin
          accept_c   = 1'b1;
          cnt_next   = '0;
          state_next = S_ITER;
        end
      end
      S_ITER: begin
        iter_c = 1'b1;
        if (cnt == LAST) begin
          state_next = S_DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        finish_c   = 1'b1;
        cnt_next   = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      busy      <= (state_next != S_IDLE);
      out_valid <= finish_c;
    end
  end

  // One slice term; the top slice of a signed b carries negative weight 2^CHUNK on its MSB.
  always_comb begin
    a_ext_c   = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    slice_c   = b_sh[CHUNK-1:0];
    top_neg_c = sgn_q && (cnt == LAST) && slice_c[CHUNK-1];
    term_c    = a_sh * PW'(slice_c);
    if (top_neg_c) begin
      term_c = term_c - (a_sh << CHUNK);
    end
    if (sgn_q) begin
      b_next_c = $signed(b_sh) >>> CHUNK;
    end else begin
      b_next_c = b_sh >> CHUNK;
    end
  end

  // Accumulator update with two's-complement overflow detection on the signed register.
  always_comb begin
    p_ext_c = ACC_WIDTH'(psum);
    if (sgn_q && psum[PW-1]) begin
      p_ext_c = p_ext_c | EXT_MASK;
    end
    is_sub_c = (mode_q == MODE_SUB);
    addend_c = is_sub_c ? ~p_ext_c : p_ext_c;
    sum_c    = acc + addend_c + ACC_WIDTH'(is_sub_c);
    ovf_c    = (acc[ACC_WIDTH-1] == addend_c[ACC_WIDTH-1]) &&
               (sum_c[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
`ifdef PIPELINED_MAC_SATURATE_EN
    if (ovf_c) begin
      mac_c = acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      mac_c = sum_c;
    end
`else
    mac_c = sum_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sgn_q   <= 1'b0;
      mode_q  <= MODE_MUL;
      psum    <= '0;
      p       <= '0;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      if (accept_c) begin
        a_sh   <= a_ext_c;
        b_sh   <= b;
        sgn_q  <= is_signed;
        mode_q <= mode_e'(mode);
        psum   <= '0;
      end else if (iter_c) begin
        psum <= psum + term_c;
        a_sh <= a_sh << CHUNK;
        b_sh <= b_next_c;
      end
      if (finish_c) begin
        p <= psum;
        unique case (mode_q)
          MODE_ADD, MODE_SUB: begin
            acc <= mac_c;
            if (ovf_c) begin
              acc_ovf <= 1'b1;
            end
          end
          MODE_LOAD: begin
            acc     <= p_ext_c;
            acc_ovf <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/pipelined_mac_multiplier.md
Name: pipelined_mac_multiplier

Overview:
- Parametrised successor to the fixed 18x18 signed pipelined multiplier.
- Multi-cycle chunked multiplier: generic operand width, signed/unsigned select, internal accumulator with multiply, MAC-add, MAC-subtract and load modes.
- Keeps the input_rdy/busy handshake and adds a one-cycle out_valid strobe.
- Sits beside the CPU as a memory-mapped math peripheral; the SoC bus wrapper drives input_rdy and samples results on out_valid.

Parameters:
- WIDTH, 18, operand width of a and b (>=4).
- CHUNK, 6, bits of b consumed per iteration cycle (1..WIDTH); N = ceil(WIDTH/CHUNK) iterations.
- ACC_WIDTH, 2*WIDTH+4, accumulator width (>= 2*WIDTH), always a signed register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset, sampled on clk rising edge.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- mode  in  2  00 MUL (acc untouched), 01 ACC+=p, 10 ACC-=p, 11 LOAD (acc=p, clears acc_ovf).
- input_rdy  in  1  request; accepted on an edge where input_rdy=1 and busy=0.
- busy  out  1  high while an operation is in flight.
- out_valid  out  1  one-cycle pulse when p/acc hold the new result.
- p  out  2*WIDTH  full product of the latest operation; holds until the next completion.
- acc  out  ACC_WIDTH  accumulator value.
- acc_ovf  out  1  sticky signed-overflow flag for acc.

Behaviour:
- Reset (resetn=0 at an edge): busy=0, out_valid=0, p=0, acc=0, acc_ovf=0, iteration counter=0. Wins over everything, including an operation in flight, which is abandoned with no out_valid.
- Accept edge E0 (input_rdy=1, busy=0): latch a, b, is_signed, mode; clear partial sum; busy=1.
- Input changes after E0 have no effect. input_rdy while busy=1 is ignored; nothing is queued.
- Edges E1..EN: each adds one CHUNK-bit slice of latched b (LSB slice first) times latched a, shifted by k*CHUNK, into the partial sum.
  - Top slice is shorter when WIDTH%CHUNK != 0.
  - When is_signed=1, the top slice carries the sign of b (negative weight); a is sign-extended.
- Edge E(N+1): p <= partial sum truncated to 2*WIDTH; acc updated per mode; out_valid=1 for this cycle only; busy=0.
  - Defaults (N=3): busy high 4 cycles; out_valid 4 cycles after the accept edge.
- Earliest next accept is edge E(N+2): busy is sampled low at E(N+2), not at E(N+1).
- Result must equal the exact product, mod 2^(2*WIDTH), of the operands interpreted per is_signed.
- Accumulator extension: p is sign-extended to ACC_WIDTH if is_signed=1, zero-extended if 0.
- acc_ovf: set when an ACC+=/ACC-= result overflows signed ACC_WIDTH range. Cleared only by LOAD or reset. MUL mode leaves acc and acc_ovf unchanged.
- out_valid is never asserted while busy=1 is also asserted at the same edge's output, except at completion, where busy has already dropped (same cycle).

Optional Feature:
- Macro: PIPELINED_MAC_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^(ACC_WIDTH-1)-1 (positive) or -2^(ACC_WIDTH-1) (negative); acc_ovf sets.
- Undefined: acc wraps modulo 2^ACC_WIDTH; acc_ovf still sets.
- LOAD behaves identically in both builds.

Test Plan:
- Signed MUL, defaults: a=50, b=-100, is_signed=1, mode=00, input_rdy pulse -> busy high 4 cycles, out_valid 4 cycles after accept, p=36'hFFFFFEC78, acc stays 0.
- Unsigned vs signed: a=b=18'h3FFFF, is_signed=0 -> p=36'hFFFF80001; same operands with is_signed=1 -> p=36'h000000001.
- MAC sequence (signed): LOAD 7*8 -> acc=56; ACC+= 3*4 -> acc=68; ACC-= 10*10 -> acc=-32 (40'hFFFFFFFFE0); acc_ovf=0 throughout.
- Overflow: LOAD a=b=18'h20000 signed (acc=2^34), then 31x ACC+= same operands.
  - With PIPELINED_MAC_SATURATE_EN: acc=40'h7FFFFFFFFF, acc_ovf=1.
  - Without: acc=40'h8000000000, acc_ovf=1.
  - A following LOAD 1*1 -> acc=1, acc_ovf=0.
- Handshake/reset: hold input_rdy=1 continuously -> accepts every 5 cycles, each with exactly one out_valid pulse. Change a/b mid-operation -> result uses the latched values. Drop resetn for one edge mid-operation -> next cycle busy=0, p=0, acc=0, no out_valid.
- Parameter sweep: WIDTH=16/CHUNK=5 (N=4, busy 5 cycles) and WIDTH=8/CHUNK=8 (N=1, busy 2 cycles). 500 random signed/unsigned operand pairs per config, each checked against the exact product.
